// File: rtl/control_contador_bcd.sv
// control_contador_bcd
//   Run-control sequencer for a cascade of BCD decade counters. It holds a
//   clock prescaler, an IDLE/RUN/PAUSE/DONE state machine and the BCD count.
//   It reports the per-digit carries, a terminal-count stop (done) and a sticky
//   overflow flag for an all-9s to all-0s wrap.
//
//   Parameters
//     DIGITS    number of cascaded decade digits (>=1), digit 0 least significant
//     PRESCALE  clk cycles per count increment (>=1)
//
//   Ports
//     clk       system clock, rising edge
//     rst       synchronous active-high reset
//     start     level: IDLE/PAUSE -> RUN
//     stop      level: RUN -> PAUSE
//     clear     level: any state -> IDLE, count and flags zeroed
//     limit_en  enables the terminal-count stop
//     limit     BCD terminal value, digit i at [4i+3:4i]
//     bcd       current count, digit i at [4i+3:4i]
//     tick      high in the cycle in which the count increments
//     carry     carry[i] high on a tick when digits 0..i are all 9
//     running   state is RUN
//     done      state is DONE
//     overflow  sticky wrap flag, cleared by clear or rst
module control_contador_bcd #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  limit_en,
    input  logic [4*DIGITS-1:0]   limit,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  tick,
    output logic [DIGITS-1:0]     carry,
    output logic                  running,
    output logic                  done,
    output logic                  overflow
);

    localparam int              PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   P_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic [PW-1:0]         pre, pre_nxt;
    logic [4*DIGITS-1:0]   count_inc;
    logic [4*DIGITS-1:0]   bcd_nxt;
    logic                  overflow_nxt;

    // One decade step; anything at or above 9 rolls to 0 so a digit can never
    // leave the 0-9 range.
    function automatic logic [3:0] dec_inc(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    // Stop and clear both win over the tick, so a tick cycle with either
    // command asserted does not increment.
    assign tick = (state == RUN) && (pre == P_LAST) && !stop && !clear;

    // Ripple carry chain and the post-increment count used both for the
    // register update and for the terminal-count compare.
    always_comb begin
        carry     = '0;
        count_inc = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (i == 0) begin
                carry[i] = tick && (bcd[3:0] == 4'd9);
                if (tick)
                    count_inc[3:0] = dec_inc(bcd[3:0]);
            end else begin
                carry[i] = carry[i-1] && (bcd[4*i +: 4] == 4'd9);
                if (carry[i-1])
                    count_inc[4*i +: 4] = dec_inc(bcd[4*i +: 4]);
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        pre_nxt      = pre;
        bcd_nxt      = bcd;
        overflow_nxt = overflow;

        if (clear) begin
            state_nxt    = IDLE;
            pre_nxt      = '0;
            bcd_nxt      = '0;
            overflow_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pre_nxt = '0;
                    bcd_nxt = '0;
                    if (start)
                        state_nxt = RUN;
                end
                RUN: begin
                    if (stop) begin
                        // Prescaler phase is held so a resume continues where it left off.
                        state_nxt = PAUSE;
                    end else begin
                        pre_nxt = (pre == P_LAST) ? '0 : pre + PW'(1);
                        if (tick) begin
                            bcd_nxt = count_inc;
                            if (carry[DIGITS-1])
                                overflow_nxt = 1'b1;
                            // A limit digit above 9 can never equal count_inc.
                            if (limit_en && (count_inc == limit))
                                state_nxt = DONE;
                        end
                    end
                end
                PAUSE: begin
                    if (start && !stop)
                        state_nxt = RUN;
                end
                DONE: begin
                    state_nxt = DONE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pre      <= '0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            pre      <= pre_nxt;
            bcd      <= bcd_nxt;
            overflow <= overflow_nxt;
        end
    end

    assign running = (state == RUN);
    assign done    = (state == DONE);

endmodule
